// File: rtl/team_06_audio_pkg.sv
// ---------------------------------------------------------------------------
// team_06_audio_pkg
// Shared definitions for the volume-ramp audio block.
//   step_state_e : gain stepper state (IDLE = gain settled, UP/DOWN = ramping)
//   unity_gain() : gain code that passes samples through unchanged (1 << VOL_W)
// ---------------------------------------------------------------------------
package team_06_audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } step_state_e;

    function automatic int unity_gain(input int vol_w);
        return 1 << vol_w;
    endfunction

endpackage

// File: rtl/team_06_gain_stepper.sv
// ---------------------------------------------------------------------------
// team_06_gain_stepper
// Walks the applied gain one LSB at a time toward the selected target so that
// volume changes, mute and power-up never produce an audible step.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_sample_valid       sample strobe; the only event that advances the ramp
//   i_volume             target volume code
//   i_enable_volume      0 = target unity gain (bypass)
//   i_mute               1 = target zero gain (wins over volume/bypass)
//   o_cur_gain           gain currently applied to samples (0..2^VOL_W)
//   o_state              stepper state, exported for observation
//   o_ramping            applied gain differs from the target
//   o_muted              mute requested and gain has reached zero
// ---------------------------------------------------------------------------
module team_06_gain_stepper
    import team_06_audio_pkg::*;
#(
    parameter int VOL_W        = 4,
    parameter int STEP_SAMPLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sample_valid,
    input  logic [VOL_W-1:0] i_volume,
    input  logic             i_enable_volume,
    input  logic             i_mute,
    output logic [VOL_W:0]   o_cur_gain,
    output step_state_e      o_state,
    output logic             o_ramping,
    output logic             o_muted
);

    // With STEP_SAMPLES = 1 the counter is a single bit that never leaves 0.
    localparam int                 CNT_W      = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STEP_SAMPLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [VOL_W:0]     GAIN_UNITY = (VOL_W+1)'(unity_gain(VOL_W));
    localparam logic [VOL_W:0]     GAIN_ONE   = (VOL_W+1)'(1);

    logic [VOL_W:0]   w_target;
    logic             w_up;
    logic [VOL_W:0]   r_cur_gain;
    logic [CNT_W-1:0] r_step_cnt;
    step_state_e      r_state;

    always_comb begin
        w_target = {1'b0, i_volume};
        if (i_mute) begin
            w_target = '0;
        end else if (!i_enable_volume) begin
            w_target = GAIN_UNITY;
        end
    end

    assign w_up = (w_target > r_cur_gain);

    // The direction is re-derived on every accepted sample, so a target change
    // mid-ramp only redirects the next step; the sample count toward that step
    // carries over. Reaching equality parks the stepper and drops the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur_gain <= '0;
            r_step_cnt <= '0;
            r_state    <= ST_IDLE;
        end else if (i_sample_valid) begin
            if (w_target == r_cur_gain) begin
                r_state    <= ST_IDLE;
                r_step_cnt <= '0;
            end else begin
                r_state <= w_up ? ST_UP : ST_DOWN;
                if (r_step_cnt == CNT_LAST) begin
                    r_step_cnt <= '0;
                    r_cur_gain <= w_up ? (r_cur_gain + GAIN_ONE) : (r_cur_gain - GAIN_ONE);
                end else begin
                    r_step_cnt <= r_step_cnt + CNT_ONE;
                end
            end
        end
    end

    assign o_cur_gain = r_cur_gain;
    assign o_state    = r_state;
    assign o_ramping  = (r_cur_gain != w_target);
    assign o_muted    = i_mute && (r_cur_gain == '0);

endmodule

// File: rtl/team_06_volume_ramp.sv
// ---------------------------------------------------------------------------
// team_06_volume_ramp
// Scales unsigned PCM samples by a gain that ramps smoothly toward the
// requested volume, between the sample source and the PWM/DAC stage.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   sample_valid       sample strobe (audio_in valid this cycle)
//   audio_in           input sample
//   volume             target volume code (unity = 2^VOL_W)
//   enable_volume      1 = apply volume, 0 = bypass (unity target)
//   mute               1 = fade to silence
//   audio_out          scaled sample, held between strobes
//   out_valid          one-cycle strobe, audio_out updated
//   ramping            applied gain has not reached the target
//   muted              mute requested and gain is zero
//   dbg_state          gain stepper state
//
// Handshake: there is no back-pressure. A sample is accepted in any cycle with
// sample_valid = 1; its result appears on audio_out with out_valid = 1 in the
// next cycle, one result per strobe, back-to-back strobes at full rate.
// ---------------------------------------------------------------------------
module team_06_volume_ramp
    import team_06_audio_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int VOL_W        = 4,
    parameter int STEP_SAMPLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] audio_in,
    input  logic [VOL_W-1:0]  volume,
    input  logic              enable_volume,
    input  logic              mute,
    output logic [DATA_W-1:0] audio_out,
    output logic              out_valid,
    output logic              ramping,
    output logic              muted,
    output step_state_e       dbg_state
);

    localparam int PROD_W = DATA_W + VOL_W + 1;

    logic [VOL_W:0]      w_cur_gain;
    logic [PROD_W-1:0]   w_product;
    logic [DATA_W-1:0]   r_audio_out;
    logic                r_out_valid;

    team_06_gain_stepper #(
        .VOL_W        (VOL_W),
        .STEP_SAMPLES (STEP_SAMPLES)
    ) u_stepper (
        .i_clk           (clk),
        .i_rst_n         (rst),
        .i_sample_valid  (sample_valid),
        .i_volume        (volume),
        .i_enable_volume (enable_volume),
        .i_mute          (mute),
        .o_cur_gain      (w_cur_gain),
        .o_state         (dbg_state),
        .o_ramping       (ramping),
        .o_muted         (muted)
    );

    // Uses the gain before any step taken on this same strobe. Gain never
    // exceeds unity, so the shifted product always fits in DATA_W bits.
    assign w_product = PROD_W'(audio_in) * PROD_W'(w_cur_gain);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_audio_out <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= sample_valid;
            if (sample_valid) begin
                r_audio_out <= DATA_W'(w_product >> VOL_W);
            end
        end
    end

    assign audio_out = r_audio_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_team_06_volume_ramp.sv
module tb_team_06_volume_ramp;
  import team_06_audio_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [7:0]  audio_in;
  logic [3:0]  volume;
  logic        enable_volume;
  logic        mute;
  logic [7:0]  audio_out;
  logic        out_valid;
  logic        ramping;
  logic        muted;
  step_state_e dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  team_06_volume_ramp #(
    .DATA_W       (8),
    .VOL_W        (4),
    .STEP_SAMPLES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_valid  (sample_valid),
    .audio_in      (audio_in),
    .volume        (volume),
    .enable_volume (enable_volume),
    .mute          (mute),
    .audio_out     (audio_out),
    .out_valid     (out_valid),
    .ramping       (ramping),
    .muted         (muted),
    .dbg_state     (dbg_state)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       sv;
    logic [7:0] din;
    logic [7:0] exp_out;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[10];

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Linear ramp model: gain starts at g0 with the step counter at 0 and moves
  // by dir once every two accepted samples; input sample fixed at 64, so the
  // expected output is 64*gain/16 = 4*gain.
  task automatic run_ramp(input int n, input int g0, input int dir, input int tgt, input string tag);
    int g_before;
    int g_after;
    for (int k = 0; k < n; k++) begin
      audio_in     = 8'd64;
      sample_valid = 1'b1;
      tick();
      g_before = g0 + dir * (k / 2);
      g_after  = g0 + dir * ((k + 1) / 2);
      check($sformatf("%s out k=%0d", tag, k), 32'(audio_out), 32'((64 * g_before) >> 4));
      check($sformatf("%s valid k=%0d", tag, k), 32'(out_valid), 32'd1);
      check($sformatf("%s ramping k=%0d", tag, k), 32'(ramping), 32'(g_after != tgt));
      check($sformatf("%s muted k=%0d", tag, k), 32'(muted), 32'(mute && (g_after == 0)));
      check($sformatf("%s state k=%0d", tag, k), 32'(dbg_state),
            32'((dir > 0) ? ST_UP : ST_DOWN));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b0;
    sample_valid  = 1'b0;
    audio_in      = 8'd0;
    volume        = 4'd0;
    enable_volume = 1'b0;
    mute          = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst audio_out", 32'(audio_out), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst muted (mute=1)", 32'(muted), 32'd1);
    check("rst ramping (mute=1)", 32'(ramping), 32'd0);
    mute = 1'b0;
    #1;
    check("rst ramping (bypass)", 32'(ramping), 32'd1);
    check("rst muted (mute=0)", 32'(muted), 32'd0);
    rst = 1'b1;

    // 1. Power-up fade-in to unity
    run_ramp(32, 0, 1, 16, "fadein");
    check("fadein settled ramping", 32'(ramping), 32'd0);
    tick();
    check("fadein unity out", 32'(audio_out), 32'd64);
    check("fadein idle state", 32'(dbg_state), 32'(ST_IDLE));

    // 2. Ramp down to volume 6
    enable_volume = 1'b1;
    volume        = 4'd6;
    run_ramp(20, 16, -1, 6, "down6");
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("down6 steady out %0d", k), 32'(audio_out), 32'd24);
      check($sformatf("down6 steady ramping %0d", k), 32'(ramping), 32'd0);
    end
    check("down6 idle state", 32'(dbg_state), 32'(ST_IDLE));

    // 4. Mute mid-ramp: 6 -> 15, mute at gain 10, then release
    volume = 4'd15;
    run_ramp(8, 6, 1, 15, "up15");
    mute = 1'b1;
    run_ramp(20, 10, -1, 0, "mute");
    tick();
    check("mute out zero", 32'(audio_out), 32'd0);
    check("mute muted", 32'(muted), 32'd1);
    check("mute ramping", 32'(ramping), 32'd0);
    mute = 1'b0;
    #1;
    check("unmute muted drops", 32'(muted), 32'd0);
    run_ramp(30, 0, 1, 15, "unmute");
    check("unmute settled ramping", 32'(ramping), 32'd0);

    // 3. Full-code scale at gain 15, including held output on idle cycles
    tbl[0] = '{1'b1, 8'd255, 8'd239, 1'b1};
    tbl[1] = '{1'b1, 8'd0,   8'd0,   1'b1};
    tbl[2] = '{1'b0, 8'd77,  8'd0,   1'b0};
    tbl[3] = '{1'b1, 8'd128, 8'd120, 1'b1};
    tbl[4] = '{1'b0, 8'd5,   8'd120, 1'b0};
    tbl[5] = '{1'b0, 8'd5,   8'd120, 1'b0};
    tbl[6] = '{1'b1, 8'd1,   8'd0,   1'b1};
    tbl[7] = '{1'b1, 8'd17,  8'd15,  1'b1};
    tbl[8] = '{1'b1, 8'd100, 8'd93,  1'b1};
    tbl[9] = '{1'b1, 8'd16,  8'd15,  1'b1};
    for (int i = 0; i < 10; i++) begin
      sample_valid = tbl[i].sv;
      audio_in     = tbl[i].din;
      tick();
      check($sformatf("scale out row %0d", i), 32'(audio_out), 32'(tbl[i].exp_out));
      check($sformatf("scale valid row %0d", i), 32'(out_valid), 32'(tbl[i].exp_valid));
    end

    // Target returns to current gain mid-count: counter must clear
    sample_valid = 1'b1;
    audio_in     = 8'd64;
    volume       = 4'd13;
    tick();
    check("eq a out", 32'(audio_out), 32'd60);
    check("eq a state", 32'(dbg_state), 32'(ST_DOWN));
    volume = 4'd15;
    tick();
    check("eq b out", 32'(audio_out), 32'd60);
    check("eq b state", 32'(dbg_state), 32'(ST_IDLE));
    check("eq b ramping", 32'(ramping), 32'd0);
    volume = 4'd14;
    tick();
    check("eq c out", 32'(audio_out), 32'd60);
    tick();
    check("eq d out (no early step)", 32'(audio_out), 32'd60);
    tick();
    check("eq e out", 32'(audio_out), 32'd56);

    // 5. Reset mid-ramp, asserted between clock edges
    volume = 4'd0;
    run_ramp(5, 14, -1, 0, "prerst");
    #2;
    rst = 1'b0;
    #1;
    check("async rst audio_out", 32'(audio_out), 32'd0);
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst ramping", 32'(ramping), 32'd0);
    check("async rst state", 32'(dbg_state), 32'(ST_IDLE));
    enable_volume = 1'b0;
    #1;
    check("async rst gain zero", 32'(ramping), 32'd1);
    #1;
    rst = 1'b1;
    run_ramp(6, 0, 1, 16, "refade");

    // 6. Strobe every 5th cycle: gain 3 -> 6 over six strobes
    for (int s = 0; s < 6; s++) begin
      sample_valid = 1'b1;
      audio_in     = 8'd64;
      tick();
      check($sformatf("gap strobe out %0d", s), 32'(audio_out), 32'(4 * (3 + s / 2)));
      check($sformatf("gap strobe valid %0d", s), 32'(out_valid), 32'd1);
      sample_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        tick();
        check($sformatf("gap hold out %0d.%0d", s, c), 32'(audio_out), 32'(4 * (3 + s / 2)));
        check($sformatf("gap hold valid %0d.%0d", s, c), 32'(out_valid), 32'd0);
      end
    end
    sample_valid = 1'b1;
    tick();
    check("gap final out", 32'(audio_out), 32'd24);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/team_06_volume_ramp.md
# team_06_volume_ramp

Parametrised successor to the volume shifter, placed between the audio sample source and the PWM/DAC output stage. It scales each incoming unsigned PCM sample by a gain register. The gain does not jump to a new volume setting: it steps one LSB at a time toward the target, paced by the sample strobe, so volume changes, mute and power-up fade without zipper noise or pops. Output is registered, with one-cycle latency and a valid strobe.

## Interface
Parameters:
- DATA_W, 8, sample width (unsigned PCM)
- VOL_W, 4, volume code width; unity gain = 2^VOL_W
- STEP_SAMPLES, 2, accepted samples per one-LSB gain step (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sample_valid  in  1  one-cycle strobe, audio_in valid
- audio_in  in  DATA_W  input sample
- volume  in  VOL_W  target volume code
- enable_volume  in  1  1 = apply volume; 0 = bypass (target unity)
- mute  in  1  1 = fade to silence (overrides volume/bypass)
- audio_out  out  DATA_W  scaled sample, held between strobes
- out_valid  out  1  one-cycle strobe, audio_out updated
- ramping  out  1  current gain ≠ target gain
- muted  out  1  mute=1 and current gain = 0

## Operation
- target_gain (VOL_W+1 bits) is evaluated combinationally every cycle: mute → 0; else !enable_volume → 2^VOL_W; else zero-extended volume.
- cur_gain (VOL_W+1 bits) holds the applied gain.
- On sample_valid: product = audio_in × cur_gain, width DATA_W+VOL_W+1. The register takes product >> VOL_W, truncated. No saturation is needed, since cur_gain ≤ 2^VOL_W. The product uses cur_gain as it was before any same-cycle step.
- Step FSM with states IDLE, UP and DOWN:
  - State is re-derived each accepted sample by comparing cur_gain with target_gain.
  - IDLE means equal. step_cnt is held at 0.
  - UP and DOWN: step_cnt increments on each sample_valid. When sample_valid arrives with step_cnt = STEP_SAMPLES−1, cur_gain moves ±1 toward target and step_cnt clears.
  - A target change mid-ramp takes effect at the next step. If it reverses direction, step_cnt is not cleared. If the new target equals cur_gain, the FSM goes to IDLE and step_cnt clears.
- cur_gain never overshoots the target. It never leaves the range 0..2^VOL_W.
- Without sample_valid, nothing changes: gain, counter and audio_out all hold.

## Timing
- Reset values: audio_out = 0, out_valid = 0, cur_gain = 0, step_cnt = 0, state = IDLE.
  - ramping and muted are derived combinationally from registered state and the current inputs.
  - The design therefore powers up silent and fades in.
- Asserting rst at any time, including mid-ramp, clears all state immediately (asynchronously).
- Latency: a strobe in cycle N produces audio_out and out_valid = 1 in cycle N+1. out_valid is 1 for exactly one cycle per strobe.
- Back-to-back strobes are supported, with full throughput of one sample per cycle.
- Full ramp time is |Δgain| × STEP_SAMPLES samples. Example: 0 → unity with defaults takes 32 samples.

## Structure
- Shared package team_06_audio_pkg:
  - typedef of step state enum {IDLE, UP, DOWN}
  - localparam function for unity gain (1 << VOL_W)
- One natural sub-module, team_06_gain_stepper. It contains:
  - target selection
  - step_cnt
  - the cur_gain FSM
  - ramping and muted outputs
- The top module keeps the multiplier and the output register.

## Test plan
All scenarios use defaults DATA_W=8, VOL_W=4, STEP_SAMPLES=2, and sample_valid every cycle unless stated.
1. Power-up fade-in: release reset; enable_volume=0, mute=0, audio_in=64. First out is 0. Gain rises 1 per 2 samples. After 32 samples audio_out=64 and ramping=0.
2. Ramp down: from unity, set enable_volume=1, volume=6. Gain reaches 6 after 20 samples with no overshoot. Steady audio_out = 64×6>>4 = 24.
3. Full-code scale: volume=15 (settled), audio_in=255 → audio_out = 239. audio_in=0 → 0.
4. Mute mid-ramp: during a 6→15 ramp at gain 10, assert mute. Gain reverses to 0 within 20 samples, muted=1, audio_out=0. Release mute → gain ramps back up to 15.
5. Reset mid-ramp: assert rst during a ramp. audio_out, out_valid and gain go to 0 in the same cycle without waiting for a clock edge. After release, the fade-in restarts from 0.
6. Strobe gaps: sample_valid every 5th cycle. Gain changes only on strobes (2 strobes per step). audio_out holds between strobes. out_valid pulses exactly one cycle after each strobe.
